// File: rtl/marquee_pkg.sv
// Shared definitions for the LED marquee engine.
// Holds the pattern mode encodings and the frame-to-lit-vector helper.
// frame_mask returns an active-high vector; callers truncate to their LED count.
package marquee_pkg;

   localparam logic [1:0] MODE_SHL    = 2'd0;
   localparam logic [1:0] MODE_SHR    = 2'd1;
   localparam logic [1:0] MODE_BOUNCE = 2'd2;
   localparam logic [1:0] MODE_CONV   = 2'd3;

   // Widest LED bank the helper can describe.
   localparam int MAX_LED = 64;

   // Lit set for frame index pos of an n-LED bank (bit i high = LED i lit).
   function automatic logic [MAX_LED-1:0] frame_mask(input logic [1:0] mode,
                                                     input int pos,
                                                     input int n);
      logic [MAX_LED-1:0] one;
      logic [MAX_LED-1:0] m;
      one = MAX_LED'(1);
      m   = '0;
      case (mode)
         MODE_SHR:  m = one << (n - 1 - pos);
         MODE_CONV: m = (one << pos) | (one << (n - 1 - pos));
         default:   m = one << pos;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/marquee_tick_div.sv
// Clock-enable prescaler: strobe is high for one cycle every DIV enabled cycles.
// Ports: clk, reset (async, active-high), en (count enable) -> strobe (combinational from count).
// Latency: strobe asserts in the DIV-th enabled cycle after reset; en=0 freezes the count.
module marquee_tick_div #(
   parameter int DIV = 12_500_000
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic strobe
);

   // At least one bit so that DIV=1 still has a (constant-zero) counter.
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign strobe = en && (cnt_q == CW'(DIV - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (strobe) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/marquee_gen.sv
// LED marquee engine: rotate left/right, bounce or converge/diverge, one frame per prescaler strobe.
// Ports: clk, reset (async, active-high), en, mode[1:0] in; led[N_LED-1:0], step, wrap out (all registered).
// Latency: led changes on the strobe edge itself; step/wrap pulse for the cycle that follows. en=0 freezes all.
module marquee_gen #(
   parameter int N_LED      = 12,
   parameter int DIV        = 12_500_000,
   parameter int ACTIVE_LOW = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [1:0]       mode,
   output logic [N_LED-1:0] led,
   output logic             step,
   output logic             wrap
);

   import marquee_pkg::*;

   localparam int PW = $clog2(N_LED);
   localparam int H  = (N_LED - 1) / 2;

   // Reset frame: LED 0 lit, expressed in pin polarity.
   localparam logic [N_LED-1:0] LED_ONE = N_LED'(1);
   localparam logic [N_LED-1:0] LED_RST = (ACTIVE_LOW != 0) ? ~LED_ONE : LED_ONE;

   logic             strobe;

   logic [1:0]       mode_q, mode_d;
   logic [PW-1:0]    pos_q, pos_d;
   logic             dir_q, dir_d;
   logic [N_LED-1:0] led_q, led_d;
   logic             step_q, step_d;
   logic             wrap_q, wrap_d;

   int               p_cur;
   int               p_nxt;
   int               lim;
   logic             dir_nxt;
   logic             restart;
   logic [1:0]       sel_mode;
   int               sel_pos;
   logic [N_LED-1:0] lit;

   marquee_tick_div #(
      .DIV (DIV)
   ) u_tick_div (
      .clk    (clk),
      .reset  (reset),
      .en     (en),
      .strobe (strobe)
   );

   // Next frame index for the current mode, assuming no mode change.
   always_comb begin
      p_cur   = int'(pos_q);
      lim     = (mode_q == MODE_CONV) ? H : (N_LED - 1);
      p_nxt   = 0;
      dir_nxt = dir_q;
      if (mode_q == MODE_SHL || mode_q == MODE_SHR) begin
         p_nxt = (p_cur == N_LED - 1) ? 0 : p_cur + 1;
      end else if (lim == 0) begin
         // Converge with a 2-LED bank: the single frame repeats forever.
         p_nxt   = 0;
         dir_nxt = 1'b0;
      end else if (!dir_q) begin
         p_nxt   = p_cur + 1;
         dir_nxt = (p_nxt == lim);
      end else begin
         p_nxt   = p_cur - 1;
         dir_nxt = (p_nxt != 0);
      end
   end

   // A pending mode change overrides the normal advance, including a wrap on the same edge.
   always_comb begin
      restart  = (mode != mode_q);
      sel_mode = restart ? mode : mode_q;
      sel_pos  = restart ? 0 : p_nxt;
      lit      = N_LED'(frame_mask(sel_mode, sel_pos, N_LED));

      mode_d = mode_q;
      pos_d  = pos_q;
      dir_d  = dir_q;
      led_d  = led_q;
      step_d = 1'b0;
      wrap_d = 1'b0;
      if (strobe) begin
         mode_d = sel_mode;
         pos_d  = PW'(sel_pos);
         dir_d  = restart ? 1'b0 : dir_nxt;
         led_d  = (ACTIVE_LOW != 0) ? ~lit : lit;
         step_d = 1'b1;
         wrap_d = (sel_pos == 0);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_q <= MODE_SHL;
         pos_q  <= '0;
         dir_q  <= 1'b0;
         led_q  <= LED_RST;
         step_q <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         mode_q <= mode_d;
         pos_q  <= pos_d;
         dir_q  <= dir_d;
         led_q  <= led_d;
         step_q <= step_d;
         wrap_q <= wrap_d;
      end
   end

   assign led  = led_q;
   assign step = step_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_marquee_gen.sv
// Directed bench for marquee_gen: main instance 12 LEDs / DIV=4, plus DIV=1 instances with 2 and 5 LEDs.
// Inputs are driven and outputs sampled 1ns after each rising edge.
// Shared clk/reset/en; each instance has its own mode input.
module tb_marquee_gen;

   logic        clk;
   logic        reset;
   logic        en;
   logic [1:0]  mode0, mode1, mode2;
   logic [11:0] led0;
   logic [1:0]  led1;
   logic [4:0]  led2;
   logic        step0, wrap0, step1, wrap1, step2, wrap2;

   int errors = 0;
   int checks = 0;

   marquee_gen #(.N_LED(12), .DIV(4), .ACTIVE_LOW(1)) dut0 (
      .clk(clk), .reset(reset), .en(en), .mode(mode0),
      .led(led0), .step(step0), .wrap(wrap0));

   marquee_gen #(.N_LED(2), .DIV(1), .ACTIVE_LOW(1)) dut1 (
      .clk(clk), .reset(reset), .en(en), .mode(mode1),
      .led(led1), .step(step1), .wrap(wrap1));

   marquee_gen #(.N_LED(5), .DIV(1), .ACTIVE_LOW(1)) dut2 (
      .clk(clk), .reset(reset), .en(en), .mode(mode2),
      .led(led2), .step(step2), .wrap(wrap2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance to the cycle in which dut0 shows a new frame; bounded.
   task automatic wait_step();
      bit got;
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (step0 === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         errors++;
         checks++;
         $display("FAIL wait_step: step never seen within 40 cycles");
      end
   endtask

   task automatic chk_led0(input string name, input logic [11:0] exp);
      checks++;
      if (led0 !== exp) begin
         errors++;
         $display("FAIL %s: led=%h expected %h", name, led0, exp);
      end
   endtask

   task automatic chk_wrap0(input string name, input logic exp);
      checks++;
      if (wrap0 !== exp) begin
         errors++;
         $display("FAIL %s: wrap=%b expected %b", name, wrap0, exp);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      en    = 1'b0;
      mode0 = 2'd0;
      mode1 = 2'd2;
      mode2 = 2'd3;
      #2;
      chk_led0("reset_led", 12'hFFE);
      checks++;
      if (step0 !== 1'b0 || wrap0 !== 1'b0) begin
         errors++;
         $display("FAIL reset_pulses: step=%b wrap=%b expected 0 0", step0, wrap0);
      end
      tick();
      tick();
      reset = 1'b0;
      en    = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if (step0 !== 1'b0 || led0 !== 12'hFFE) begin
         errors++;
         $display("FAIL early_step: step=%b led=%h expected 0 FFE", step0, led0);
      end
      tick();
      checks++;
      if (step0 !== 1'b1) begin
         errors++;
         $display("FAIL first_step: step=%b expected 1", step0);
      end
      chk_led0("first_step_led", 12'hFFD);
      chk_wrap0("first_step_wrap", 1'b0);
      tick();
      checks++;
      if (step0 !== 1'b0) begin
         errors++;
         $display("FAIL step_width: step=%b expected 0", step0);
      end
   endtask

   task automatic test_shl_wrap();
      logic [11:0] one;
      one = 12'h001;
      for (int k = 2; k <= 12; k++) begin
         wait_step();
         chk_led0("shl_led", ~(one << (k % 12)));
         chk_wrap0("shl_wrap", (k == 12));
      end
   endtask

   task automatic test_shr();
      mode0 = 2'd1;
      wait_step();
      chk_led0("shr_frame0", 12'h7FF);
      chk_wrap0("shr_wrap", 1'b1);
   endtask

   task automatic test_converge();
      logic [11:0] tbl [10];
      tbl = '{12'hBFD, 12'hDFB, 12'hEF7, 12'hF6F, 12'hF9F,
              12'hF6F, 12'hEF7, 12'hDFB, 12'hBFD, 12'h7FE};
      mode0 = 2'd3;
      wait_step();
      chk_led0("conv_frame0", 12'h7FE);
      chk_wrap0("conv_restart_wrap", 1'b1);
      for (int i = 0; i < 10; i++) begin
         wait_step();
         chk_led0("conv_led", tbl[i]);
         chk_wrap0("conv_wrap", (i == 9));
      end
   endtask

   task automatic test_bounce();
      logic [11:0] one;
      int p;
      one   = 12'h001;
      mode0 = 2'd2;
      wait_step();
      chk_led0("bounce_frame0", 12'hFFE);
      chk_wrap0("bounce_restart_wrap", 1'b1);
      for (int k = 1; k <= 22; k++) begin
         wait_step();
         p = (k <= 11) ? k : 22 - k;
         chk_led0("bounce_led", ~(one << p));
         chk_wrap0("bounce_wrap", (k == 22));
      end
   endtask

   task automatic test_en_hold();
      logic [11:0] held_led;
      bit          bad;
      tick();
      tick();
      en       = 1'b0;
      held_led = led0;
      bad      = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (step0 !== 1'b0 || led0 !== held_led) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL en_hold: step/led moved while en=0 (led=%h expected %h)", led0, held_led);
      end
      en = 1'b1;
      tick();
      checks++;
      if (step0 !== 1'b0) begin
         errors++;
         $display("FAIL en_resume_early: step=%b expected 0", step0);
      end
      tick();
      checks++;
      if (step0 !== 1'b1) begin
         errors++;
         $display("FAIL en_resume_step: step=%b expected 1", step0);
      end
      chk_led0("en_resume_led", 12'hFFD);
   endtask

   task automatic test_mode_change();
      mode0 = 2'd0;
      wait_step();
      chk_led0("mc_shl_frame0", 12'hFFE);
      for (int i = 0; i < 5; i++) wait_step();
      chk_led0("mc_pos5", 12'hFDF);
      tick();
      mode0 = 2'd2;
      tick();
      checks++;
      if (led0 !== 12'hFDF || step0 !== 1'b0) begin
         errors++;
         $display("FAIL mc_between: led=%h step=%b expected FDF 0", led0, step0);
      end
      wait_step();
      chk_led0("mc_bounce_frame0", 12'hFFE);
      chk_wrap0("mc_wrap", 1'b1);
   endtask

   task automatic test_wrap_and_change();
      mode0 = 2'd0;
      wait_step();
      for (int i = 0; i < 11; i++) wait_step();
      chk_led0("wc_pos11", 12'h7FF);
      mode0 = 2'd3;
      wait_step();
      chk_led0("wc_restart_led", 12'h7FE);
      chk_wrap0("wc_restart_wrap", 1'b1);
   endtask

   task automatic test_reset_mid();
      mode0 = 2'd0;
      wait_step();
      reset = 1'b1;
      #2;
      chk_led0("mid_reset_led", 12'hFFE);
      checks++;
      if (step0 !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_step: step=%b expected 0", step0);
      end
      #1;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if (step0 !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_early: step=%b expected 0", step0);
      end
      tick();
      checks++;
      if (step0 !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_step_at_div: step=%b expected 1", step0);
      end
      chk_led0("mid_reset_first_led", 12'hFFD);
   endtask

   task automatic test_small();
      logic [1:0] exp1 [5];
      logic [4:0] exp2 [5];
      logic       expw1 [5];
      logic       expw2 [5];
      exp1  = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
      expw1 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      exp2  = '{5'h0E, 5'h15, 5'h1B, 5'h15, 5'h0E};
      expw2 = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      tick();
      reset = 1'b1;
      mode1 = 2'd2;
      mode2 = 2'd3;
      #2;
      checks++;
      if (led1 !== 2'b10 || led2 !== 5'h1E) begin
         errors++;
         $display("FAIL small_reset: led1=%b led2=%h expected 10 1E", led1, led2);
      end
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (led1 !== exp1[i] || wrap1 !== expw1[i] || step1 !== 1'b1) begin
            errors++;
            $display("FAIL n2_bounce[%0d]: led=%b wrap=%b step=%b expected %b %b 1",
                     i, led1, wrap1, step1, exp1[i], expw1[i]);
         end
         checks++;
         if (led2 !== exp2[i] || wrap2 !== expw2[i] || step2 !== 1'b1) begin
            errors++;
            $display("FAIL n5_conv[%0d]: led=%h wrap=%b step=%b expected %h %b 1",
                     i, led2, wrap2, step2, exp2[i], expw2[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_shl_wrap();
      test_shr();
      test_converge();
      test_bounce();
      test_en_hold();
      test_mode_change();
      test_wrap_and_change();
      test_reset_mid();
      test_small();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
